// File: rtl/cache_fill_arbiter_pkg.sv
// Shared definitions for the cache fill arbiter and the cache modules that size
// their data arrays from the same block geometry.
package cache_fill_arbiter_pkg;

    localparam int WORDS_PER_BLK_DEF = 8;
    localparam int MEM_LAT_DEF       = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DONE  = 2'd2,
        WRITE = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_e;

endpackage

// File: rtl/cache_fill_arbiter_fill_word_counter.sv
// Issue / receive word counters for one block fill. Both counters saturate at
// WORDS_PER_BLK so a late increment can never wrap back into a valid index.
// Reset is synchronous and active-high on rst_n.
module fill_word_counter #(
    parameter int WORDS_PER_BLK = 8,
    parameter int CNT_W         = $clog2(WORDS_PER_BLK) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             issue_inc,
    input  logic             recv_inc,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [CNT_W-1:0] recv_cnt,
    output logic             issue_term,
    output logic             recv_last
);

    logic recv_term;

    assign issue_term = (issue_cnt == CNT_W'(WORDS_PER_BLK));
    assign recv_term  = (recv_cnt  == CNT_W'(WORDS_PER_BLK));
    assign recv_last  = (recv_cnt  == CNT_W'(WORDS_PER_BLK - 1));

    // Counter state: clear (optionally pre-counting the first issue) or saturating increment.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            issue_cnt <= {CNT_W{1'b0}};
            recv_cnt  <= {CNT_W{1'b0}};
        end else if (clear) begin
            issue_cnt <= {{(CNT_W-1){1'b0}}, issue_inc};
            recv_cnt  <= {CNT_W{1'b0}};
        end else begin
            if (issue_inc && !issue_term) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
            if (recv_inc && !recv_term) begin
                recv_cnt <= recv_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbiter for the shared main-memory port: I-cache fills, D-cache fills and
// D-cache write-through stores. Reset is synchronous and active-high on rst_n.
// Optional build macro CACHE_FILL_ARB_RR_EN: alternate I/D grants when both
// misses are pending (default build gives the D-cache fixed priority).
module cache_fill_arbiter
    import cache_fill_arbiter_pkg::*;
#(
    parameter  int ADDR_W        = 16,
    parameter  int DATA_W        = 16,
    parameter  int WORDS_PER_BLK = WORDS_PER_BLK_DEF,
    parameter  int MEM_LAT       = MEM_LAT_DEF,
    localparam int IDX_W         = $clog2(WORDS_PER_BLK)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_miss,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic              dc_miss,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic              dc_wr_req,
    input  logic [ADDR_W-1:0] dc_wr_addr,
    input  logic [DATA_W-1:0] dc_wr_data,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic [DATA_W-1:0] fill_data,
    output logic [IDX_W-1:0]  fill_idx,
    output logic              ic_fill_we,
    output logic              dc_fill_we,
    output logic              ic_fill_done,
    output logic              dc_fill_done,
    output logic              dc_wr_ack,
    output logic              fill_busy
);

    localparam int CNT_W = IDX_W + 1;
    // Byte offset within a block spans IDX_W word bits plus the byte-in-word bit.
    localparam logic [ADDR_W-1:0] BLK_MASK = ~(ADDR_W'(2 * WORDS_PER_BLK - 1));

    if (WORDS_PER_BLK < 2 || (WORDS_PER_BLK & (WORDS_PER_BLK - 1)) != 0) begin : g_bad_wpb
        $error("WORDS_PER_BLK must be a power of two");
    end
    if (MEM_LAT < 1) begin : g_bad_lat
        $error("MEM_LAT must be at least 1");
    end

    arb_state_e        state;
    owner_e            owner;
    logic [ADDR_W-1:0] base;

    logic              grant_fill;
    logic              grant_write;
    owner_e            grant_owner;
    logic [ADDR_W-1:0] grant_base;

    logic              cnt_clear;
    logic              cnt_issue_inc;
    logic              cnt_recv_inc;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  recv_cnt;
    logic              issue_term;
    logic              recv_last;

`ifdef CACHE_FILL_ARB_RR_EN
    owner_e            last_owner;

    // Remember who won the last fill so simultaneous misses alternate.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            last_owner <= OWN_IC;
        end else if (state == IDLE && grant_fill) begin
            last_owner <= grant_owner;
        end else begin
            last_owner <= last_owner;
        end
    end
`endif

    // Request selection: misses beat stores; D beats I unless alternating.
    always_comb begin
        grant_fill  = 1'b0;
        grant_write = 1'b0;
        grant_owner = OWN_DC;
        if (ic_miss && dc_miss) begin
            grant_fill = 1'b1;
`ifdef CACHE_FILL_ARB_RR_EN
            grant_owner = (last_owner == OWN_DC) ? OWN_IC : OWN_DC;
`else
            grant_owner = OWN_DC;
`endif
        end else if (dc_miss) begin
            grant_fill  = 1'b1;
            grant_owner = OWN_DC;
        end else if (ic_miss) begin
            grant_fill  = 1'b1;
            grant_owner = OWN_IC;
        end else if (dc_wr_req) begin
            grant_write = 1'b1;
        end else begin
            grant_write = 1'b0;
        end
    end

    assign grant_base = ((grant_owner == OWN_DC) ? dc_addr : ic_addr) & BLK_MASK;

    // Counter control: word 0 is issued on the grant edge, so the clear pre-counts it.
    always_comb begin
        cnt_clear     = 1'b0;
        cnt_issue_inc = 1'b0;
        cnt_recv_inc  = 1'b0;
        case (state)
            IDLE: begin
                cnt_clear     = 1'b1;
                cnt_issue_inc = grant_fill;
            end
            FILL: begin
                cnt_issue_inc = !issue_term;
                cnt_recv_inc  = mem_rvalid;
            end
            default: begin
                cnt_clear = 1'b0;
            end
        endcase
    end

    fill_word_counter #(
        .WORDS_PER_BLK (WORDS_PER_BLK),
        .CNT_W         (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (cnt_clear),
        .issue_inc  (cnt_issue_inc),
        .recv_inc   (cnt_recv_inc),
        .issue_cnt  (issue_cnt),
        .recv_cnt   (recv_cnt),
        .issue_term (issue_term),
        .recv_last  (recv_last)
    );

    // Main FSM with all memory-side and cache-side outputs registered; outputs idle at 0.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state        <= IDLE;
            owner        <= OWN_IC;
            base         <= {ADDR_W{1'b0}};
            mem_en       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_addr     <= {ADDR_W{1'b0}};
            mem_wdata    <= {DATA_W{1'b0}};
            fill_data    <= {DATA_W{1'b0}};
            fill_idx     <= {IDX_W{1'b0}};
            ic_fill_we   <= 1'b0;
            dc_fill_we   <= 1'b0;
            ic_fill_done <= 1'b0;
            dc_fill_done <= 1'b0;
            dc_wr_ack    <= 1'b0;
        end else begin
            mem_en       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_addr     <= {ADDR_W{1'b0}};
            mem_wdata    <= {DATA_W{1'b0}};
            fill_data    <= {DATA_W{1'b0}};
            fill_idx     <= {IDX_W{1'b0}};
            ic_fill_we   <= 1'b0;
            dc_fill_we   <= 1'b0;
            ic_fill_done <= 1'b0;
            dc_fill_done <= 1'b0;
            dc_wr_ack    <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_fill) begin
                        state    <= FILL;
                        owner    <= grant_owner;
                        base     <= grant_base;
                        mem_en   <= 1'b1;
                        mem_addr <= grant_base;
                    end else if (grant_write) begin
                        state     <= WRITE;
                        mem_en    <= 1'b1;
                        mem_wr    <= 1'b1;
                        mem_addr  <= dc_wr_addr;
                        mem_wdata <= dc_wr_data;
                        dc_wr_ack <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                FILL: begin
                    if (!issue_term) begin
                        mem_en   <= 1'b1;
                        mem_addr <= base + ADDR_W'({issue_cnt, 1'b0});
                    end
                    if (mem_rvalid) begin
                        fill_data  <= mem_rdata;
                        fill_idx   <= recv_cnt[IDX_W-1:0];
                        ic_fill_we <= (owner == OWN_IC);
                        dc_fill_we <= (owner == OWN_DC);
                        if (recv_last) begin
                            state        <= DONE;
                            ic_fill_done <= (owner == OWN_IC);
                            dc_fill_done <= (owner == OWN_DC);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                WRITE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign fill_busy = (state != IDLE) | ic_miss | dc_miss | dc_wr_req;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Bench for cache_fill_arbiter: a latency-MEM_LAT memory model, a timeline model
// of every grant compared against the DUT each cycle, and directed scenarios.
module tb_cache_fill_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ic_miss = 1'b0, dc_miss = 1'b0, dc_wr_req = 1'b0;
    logic [15:0] ic_addr = 16'h0, dc_addr = 16'h0, dc_wr_addr = 16'h0, dc_wr_data = 16'h0;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, fill_data;
    logic [15:0] mem_rdata = 16'h0;
    logic        rv_pipe = 1'b0, stray = 1'b0;
    logic        mem_rvalid;
    logic [2:0]  fill_idx;
    logic        ic_fill_we, dc_fill_we, ic_fill_done, dc_fill_done, dc_wr_ack, fill_busy;

    assign mem_rvalid = rv_pipe | stray;

    cache_fill_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .ic_miss(ic_miss), .ic_addr(ic_addr),
        .dc_miss(dc_miss), .dc_addr(dc_addr),
        .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .fill_data(fill_data), .fill_idx(fill_idx),
        .ic_fill_we(ic_fill_we), .dc_fill_we(dc_fill_we),
        .ic_fill_done(ic_fill_done), .dc_fill_done(dc_fill_done),
        .dc_wr_ack(dc_wr_ack), .fill_busy(fill_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;

    logic [58:0] out_vec;
    assign out_vec = {mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_idx,
                      ic_fill_we, dc_fill_we, ic_fill_done, dc_fill_done, dc_wr_ack, fill_busy};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        return a ^ 16'hC35A;
    endfunction

    // Memory: a read seen with mem_en in cycle c returns in cycle c+4.
    logic        ret_v [0:63];
    logic [15:0] ret_a [0:63];
    initial begin
        for (int k = 0; k < 64; k++) begin ret_v[k] = 1'b0; ret_a[k] = 16'h0; end
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            rv_pipe   = ret_v[cyc % 64];
            mem_rdata = mem_val(ret_a[cyc % 64]);
            ret_v[cyc % 64] = 1'b0;
            @(negedge clk);
            if (mem_en === 1'b1 && mem_wr === 1'b0) begin
                ret_v[(cyc + 4) % 64] = 1'b1;
                ret_a[(cyc + 4) % 64] = mem_addr;
            end
        end
    end

    // Event logs used by the directed checks.
    int ic_we_cnt = 0, dc_we_cnt = 0, ic_done_cnt = 0, dc_done_cnt = 0;
    int ack_cnt = 0, idle_cnt = 0, rd_cnt = 0, wr_cnt = 0;
    logic [15:0] rd_log [0:255];
    logic [15:0] wr_addr_log = 16'h0, wr_data_log = 16'h0;

    // Model: each grant is a timeline relative to its grant cycle g.
    int          m_kind = 0;       // 0 none, 1 fill, 2 write
    int          m_g = 0, m_free = 0;
    bit          m_own_dc = 1'b0, m_last_dc = 1'b0;
    logic [15:0] m_base = 16'h0, m_wa = 16'h0, m_wd = 16'h0;

    initial begin
        forever begin
            @(negedge clk);
            begin
                int d;
                logic e_en, e_wr, e_icwe, e_dcwe, e_icd, e_dcd, e_ack, e_busy;
                logic [15:0] e_addr, e_wdata, e_fdata;
                logic [2:0] e_idx;
                e_en = 0; e_wr = 0; e_icwe = 0; e_dcwe = 0; e_icd = 0; e_dcd = 0; e_ack = 0; e_busy = 0;
                e_addr = 16'h0; e_wdata = 16'h0; e_fdata = 16'h0; e_idx = 3'd0;
                d = cyc - m_g;
                if (m_kind == 1 && d >= 1 && d <= 13) begin
                    e_busy = 1'b1;
                    if (d <= 8) begin e_en = 1'b1; e_addr = m_base + 16'(2 * (d - 1)); end
                    if (d >= 6) begin
                        e_idx = 3'(d - 6);
                        e_fdata = mem_val(m_base + 16'(2 * (d - 6)));
                        if (m_own_dc) e_dcwe = 1'b1; else e_icwe = 1'b1;
                    end
                    if (d == 13) begin if (m_own_dc) e_dcd = 1'b1; else e_icd = 1'b1; end
                end
                if (m_kind == 2 && d == 1) begin
                    e_busy = 1'b1; e_en = 1'b1; e_wr = 1'b1; e_addr = m_wa; e_wdata = m_wd; e_ack = 1'b1;
                end
                e_busy = e_busy | ic_miss | dc_miss | dc_wr_req;
                if (cmp_en)
                    check("outputs", 64'(out_vec),
                          64'({e_en, e_wr, e_addr, e_wdata, e_fdata, e_idx,
                               e_icwe, e_dcwe, e_icd, e_dcd, e_ack, e_busy}));
                if (ic_fill_we === 1'b1) ic_we_cnt++;
                if (dc_fill_we === 1'b1) dc_we_cnt++;
                if (ic_fill_done === 1'b1) ic_done_cnt++;
                if (dc_fill_done === 1'b1) dc_done_cnt++;
                if (dc_wr_ack === 1'b1) ack_cnt++;
                if (fill_busy === 1'b0) idle_cnt++;
                if (mem_en === 1'b1 && mem_wr === 1'b0) begin rd_log[rd_cnt % 256] = mem_addr; rd_cnt++; end
                if (mem_en === 1'b1 && mem_wr === 1'b1) begin wr_addr_log = mem_addr; wr_data_log = mem_wdata; wr_cnt++; end
                if (rst_n) begin
                    m_kind = 0; m_free = cyc + 1; m_last_dc = 1'b0;
                end else if (cyc >= m_free) begin
                    if (ic_miss || dc_miss) begin
                        if (ic_miss && dc_miss) begin
`ifdef CACHE_FILL_ARB_RR_EN
                            m_own_dc = !m_last_dc;
`else
                            m_own_dc = 1'b1;
`endif
                        end else begin
                            m_own_dc = dc_miss;
                        end
                        m_base = (m_own_dc ? dc_addr : ic_addr) & 16'hFFF0;
                        m_kind = 1; m_g = cyc; m_free = cyc + 14; m_last_dc = m_own_dc;
                    end else if (dc_wr_req) begin
                        m_kind = 2; m_g = cyc; m_free = cyc + 2; m_wa = dc_wr_addr; m_wd = dc_wr_data;
                    end else begin
                        m_kind = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // which: 0 = ic_fill_done, 1 = dc_fill_done, 2 = dc_wr_ack
    task automatic wait_for(input int which, input string name, output int t);
        bit seen = 1'b0;
        for (int k = 0; k < 80 && !seen; k++) begin
            tick();
            case (which)
                0: seen = (ic_fill_done === 1'b1);
                1: seen = (dc_fill_done === 1'b1);
                default: seen = (dc_wr_ack === 1'b1);
            endcase
        end
        t = cyc;
        if (!seen) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
    endtask

    initial begin
        int g, t1, t2, s_ic, s_dc, s_rd, s_ack, s_idle, s_wr, s_icd;
        bit seen, first_ic, exp_first_ic;

        tick(); tick();
        rst_n = 1'b0;
        cmp_en = 1'b1;
        check("reset_state", 64'(out_vec), 64'd0);

        // A: lone I-cache miss.
        tick();
        s_ic = ic_we_cnt; s_dc = dc_we_cnt; s_rd = rd_cnt;
        ic_miss = 1'b1; ic_addr = 16'h1234; g = cyc;
        wait_for(0, "A_ic_done", t1);
        check("A_latency", 64'(t1 - g), 64'd13);
        tick(); ic_miss = 1'b0;
        check("A_ic_we_count", 64'(ic_we_cnt - s_ic), 64'd8);
        check("A_dc_we_count", 64'(dc_we_cnt - s_dc), 64'd0);
        check("A_reads", 64'(rd_cnt - s_rd), 64'd8);
        check("A_first_addr", 64'(rd_log[s_rd % 256]), 64'h1230);
        check("A_last_addr", 64'(rd_log[(s_rd + 7) % 256]), 64'h123E);

        // B: both misses right after reset, D wins.
        do_reset();
        tick();
        ic_miss = 1'b1; ic_addr = 16'h1234; dc_miss = 1'b1; dc_addr = 16'h20F3; g = cyc;
        wait_for(1, "B_dc_done", t1);
        check("B_dc_latency", 64'(t1 - g), 64'd13);
        tick(); dc_miss = 1'b0;
        wait_for(0, "B_ic_done", t2);
        check("B_ic_after_dc", 64'(t2 - t1), 64'd14);
        tick(); ic_miss = 1'b0;

        // C: lone D-cache miss.
        tick();
        s_ic = ic_we_cnt; s_dc = dc_we_cnt;
        dc_miss = 1'b1; dc_addr = 16'h0A57;
        wait_for(1, "C_dc_done", t1);
        tick(); dc_miss = 1'b0;
        check("C_dc_we_count", 64'(dc_we_cnt - s_dc), 64'd8);
        check("C_ic_we_count", 64'(ic_we_cnt - s_ic), 64'd0);

        // D: both misses again after a D grant.
        tick();
        ic_miss = 1'b1; ic_addr = 16'h0100; dc_miss = 1'b1; dc_addr = 16'h0200;
        seen = 1'b0; first_ic = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            if (ic_fill_done === 1'b1 || dc_fill_done === 1'b1) begin
                seen = 1'b1; first_ic = (ic_fill_done === 1'b1);
            end
        end
        if (!seen) check("D_first_timeout", 64'd0, 64'd1);
`ifdef CACHE_FILL_ARB_RR_EN
        exp_first_ic = 1'b1;
`else
        exp_first_ic = 1'b0;
`endif
        check("D_first_owner_ic", 64'(first_ic), 64'(exp_first_ic));
        tick();
        if (first_ic) begin
            ic_miss = 1'b0; wait_for(1, "D_second", t1); tick(); dc_miss = 1'b0;
        end else begin
            dc_miss = 1'b0; wait_for(0, "D_second", t1); tick(); ic_miss = 1'b0;
        end

        // E: lone write-through store.
        tick();
        s_wr = wr_cnt;
        dc_wr_req = 1'b1; dc_wr_addr = 16'h0040; dc_wr_data = 16'hBEEF; g = cyc;
        wait_for(2, "E_ack", t1);
        check("E_ack_latency", 64'(t1 - g), 64'd1);
        tick(); dc_wr_req = 1'b0;
        check("E_write_count", 64'(wr_cnt - s_wr), 64'd1);
        check("E_write_addr", 64'(wr_addr_log), 64'h0040);
        check("E_write_data", 64'(wr_data_log), 64'hBEEF);

        // F: store arriving mid I-fill waits until after the fill.
        tick();
        ic_miss = 1'b1; ic_addr = 16'h0456;
        tick(); tick(); tick();
        dc_wr_req = 1'b1; dc_wr_addr = 16'h0088; dc_wr_data = 16'h1357;
        s_ack = ack_cnt; s_idle = idle_cnt;
        wait_for(0, "F_ic_done", t1);
        check("F_no_early_ack", 64'(ack_cnt - s_ack), 64'd0);
        tick(); ic_miss = 1'b0;
        wait_for(2, "F_ack", t2);
        check("F_ack_after_done", 64'(t2 - t1), 64'd2);
        check("F_busy_held", 64'(idle_cnt - s_idle), 64'd0);
        tick(); dc_wr_req = 1'b0;

        // G: reset during word 3 of a fill, then a normal fill.
        tick();
        ic_miss = 1'b1; ic_addr = 16'h3000;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            seen = (ic_fill_we === 1'b1 && fill_idx === 3'd3);
        end
        if (!seen) check("G_word3_timeout", 64'd0, 64'd1);
        rst_n = 1'b1; ic_miss = 1'b0;
        tick();
        rst_n = 1'b0;
        check("G_reset_outputs", 64'(out_vec), 64'd0);
        s_ic = ic_we_cnt; s_icd = ic_done_cnt;
        for (int k = 0; k < 10; k++) tick();
        check("G_no_stale_we", 64'(ic_we_cnt - s_ic), 64'd0);
        check("G_no_done", 64'(ic_done_cnt - s_icd), 64'd0);
        s_ic = ic_we_cnt;
        ic_miss = 1'b1; ic_addr = 16'h3010; g = cyc;
        wait_for(0, "G_refill_done", t1);
        check("G_refill_latency", 64'(t1 - g), 64'd13);
        tick(); ic_miss = 1'b0;
        check("G_refill_we", 64'(ic_we_cnt - s_ic), 64'd8);

        // H: stray mem_rvalid while idle.
        tick();
        s_ic = ic_we_cnt; s_dc = dc_we_cnt;
        stray = 1'b1;
        tick();
        stray = 1'b0;
        tick(); tick(); tick();
        check("H_no_ic_we", 64'(ic_we_cnt - s_ic), 64'd0);
        check("H_no_dc_we", 64'(dc_we_cnt - s_dc), 64'd0);
        check("H_idle", 64'(fill_busy), 64'd0);

        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
